// File: rtl/array_16_port_ctrl.sv
// Request-side controller for a 256x24 masked 1R1W array macro: request stream -> R0/W0 strobes,
// in-order read responses through a 2-entry buffer. Optional power-up zero walk: ARRAY16_CTRL_INIT_EN.
module array_16_port_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 24,
  parameter int SEGS   = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [SEGS-1:0]   req_mask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] R0_addr,
  output logic              R0_en,
  input  logic [DATA_W-1:0] R0_data,
  output logic [ADDR_W-1:0] W0_addr,
  output logic              W0_en,
  output logic [DATA_W-1:0] W0_data,
  output logic [SEGS-1:0]   W0_mask,
  output logic              init_done
);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] init_cnt;
  logic              init_last;
  logic              run, credit, rd_fire;
  logic              rd_vld_p1;
  logic [1:0]        cnt;
  logic              rd_ptr, wr_ptr, push, pop;
  logic [DATA_W-1:0] buf_mem [2];

`ifdef ARRAY16_CTRL_INIT_EN
  localparam state_t RST_STATE = ST_INIT;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)              init_cnt <= '0;
    else if (state == ST_INIT) init_cnt <= init_cnt + ADDR_W'(1);
  end

  assign init_last = &init_cnt;
`else
  localparam state_t RST_STATE = ST_RUN;

  assign init_cnt  = '0;
  assign init_last = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= RST_STATE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_INIT && init_last) state_nxt = ST_RUN;
  end

  // p0: request issue to the macro ports
  always_comb begin
    run = (state == ST_RUN);
    // count + inflight never exceeds 2, so one free slot exists exactly in these cases
    credit    = (cnt == 2'd0) || (cnt == 2'd1 && !rd_vld_p1);
    req_ready = run && (req_write || credit);
    rd_fire   = req_valid && req_ready && !req_write;
    R0_en     = rd_fire;
    R0_addr   = req_addr;
    W0_en     = req_valid && req_ready && req_write;
    W0_addr   = req_addr;
    W0_data   = req_wdata;
    W0_mask   = req_mask;
    if (state == ST_INIT) begin
      W0_en   = reset_n;
      W0_addr = init_cnt;
      W0_data = '0;
      W0_mask = '1;
    end
    init_done = run;
  end

  // p1: macro read data lands; bypass when the buffer is empty, otherwise queue behind it
  always_comb begin
    rsp_valid = (cnt != 2'd0) || rd_vld_p1;
    rsp_data  = (cnt == 2'd0) ? R0_data : buf_mem[rd_ptr];
    pop       = (cnt != 2'd0) && rsp_ready;
    push      = rd_vld_p1 && ((cnt != 2'd0) || !rsp_ready);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld_p1 <= 1'b0;
      cnt       <= 2'd0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
    end else begin
      rd_vld_p1 <= rd_fire;
      cnt       <= cnt + 2'(push) - 2'(pop);
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
    end
  end

  always_ff @(posedge clock) begin
    if (push) buf_mem[wr_ptr] <= R0_data;
  end

endmodule
